// File: rtl/cfg_dprio_status_capture_ctrl.sv
// Round-robin DPRIO status capture sequencer with four-phase write_en handshake.
// Define CFG_DPRIO_STATUS_TIMEOUT_EN to add the handshake watchdog and ABORT path.
module cfg_dprio_status_capture_ctrl #(
   parameter int NUM_CH         = 4,
   parameter int DATA_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_CH-1:0]              capture_req,
   output logic [NUM_CH-1:0]              write_en,
   input  logic [NUM_CH-1:0]              write_en_ack,
   input  logic [NUM_CH*DATA_WIDTH-1:0]   stat_data,
   output logic [DATA_WIDTH-1:0]          capture_data,
   output logic [$clog2(NUM_CH)-1:0]      capture_ch,
   output logic                           capture_valid,
   output logic                           timeout_err,
   output logic                           busy,
   output logic [NUM_CH-1:0]              pending
);

   localparam int CW = $clog2(NUM_CH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_DROP,
      S_CAP
`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
      , S_ABORT
`endif
   } state_t;

   state_t                r_state;
   logic [NUM_CH-1:0]     r_we;
   logic [NUM_CH-1:0]     r_pend;
   logic [DATA_WIDTH-1:0] r_data;
   logic [CW-1:0]         r_ch;
   logic [CW-1:0]         r_ptr;
   logic                  r_valid;
   logic                  r_busy;
   logic                  r_rereq;

   logic [CW-1:0]         w_gnt;
   logic                  w_any;
   logic [CW-1:0]         w_ptr_nxt;
   logic [NUM_CH-1:0]     w_sel;
   logic [NUM_CH-1:0]     w_clr;
   logic                  w_ack;
   logic                  w_done;
   logic [DATA_WIDTH-1:0] w_word;

   // Scan from the pointer upward; the lowest offset wins, so iterate downward.
   always_comb begin
      w_any = 1'b0;
      w_gnt = '0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         if (r_pend[(int'(r_ptr) + k) % NUM_CH]) begin
            w_any = 1'b1;
            w_gnt = CW'((int'(r_ptr) + k) % NUM_CH);
         end
      end
   end

   assign w_ptr_nxt = (w_gnt == CW'(NUM_CH - 1)) ? '0 : w_gnt + 1'b1;
   assign w_sel     = {{(NUM_CH-1){1'b0}}, 1'b1} << r_ch;
   assign w_ack     = write_en_ack[r_ch];
   assign w_word    = stat_data[r_ch*DATA_WIDTH +: DATA_WIDTH];

`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
   assign w_done = (r_state == S_CAP) || (r_state == S_ABORT);
`else
   assign w_done = (r_state == S_CAP);
`endif

   // A re-request seen during service keeps the bit alive past the clear.
   assign w_clr = (w_done && !r_rereq) ? w_sel : '0;

`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
   localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] r_wdog;
   logic        r_terr;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_we    <= '0;
         r_pend  <= '0;
         r_data  <= '0;
         r_ch    <= '0;
         r_ptr   <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_rereq <= 1'b0;
`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
         r_wdog  <= '0;
         r_terr  <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
         r_terr  <= 1'b0;
`endif
         r_pend  <= (r_pend & ~w_clr) | capture_req;
         if (r_state != S_IDLE && capture_req[r_ch])
            r_rereq <= 1'b1;
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_ch    <= w_gnt;
                  r_ptr   <= w_ptr_nxt;
                  r_state <= S_REQ;
                  r_busy  <= 1'b1;
                  r_rereq <= 1'b0;
`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
                  r_wdog  <= '0;
`endif
               end
            end
            S_REQ: begin
               r_we <= w_sel;
`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
               if (r_wdog == WD_LIM) begin
                  r_state <= S_ABORT;
               end else if (w_ack) begin
                  r_state <= S_DROP;
                  r_wdog  <= '0;
               end else begin
                  r_wdog  <= r_wdog + 16'd1;
               end
`else
               if (w_ack)
                  r_state <= S_DROP;
`endif
            end
            S_DROP: begin
               r_we <= '0;
`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
               if (r_wdog == WD_LIM)
                  r_state <= S_ABORT;
               else if (!w_ack)
                  r_state <= S_CAP;
               else
                  r_wdog  <= r_wdog + 16'd1;
`else
               if (!w_ack)
                  r_state <= S_CAP;
`endif
            end
            S_CAP: begin
               r_data  <= w_word;
               r_valid <= 1'b1;
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
            S_ABORT: begin
               r_we    <= '0;
               r_terr  <= 1'b1;
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign write_en      = r_we;
   assign capture_data  = r_data;
   assign capture_ch    = r_ch;
   assign capture_valid = r_valid;
   assign busy          = r_busy;
   assign pending       = r_pend;
`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
   assign timeout_err   = r_terr;
`else
   assign timeout_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cfg_dprio_status_capture_ctrl.sv
// Directed bench for cfg_dprio_status_capture_ctrl; channel acks echo
// write_en through a two-cycle delay, with stuck and stray overrides.
module tb_cfg_dprio_status_capture_ctrl;

   localparam int NCH = 4;
   localparam int DW  = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    capture_req = '0;
   logic [3:0]    write_en;
   logic [3:0]    write_en_ack;
   logic [63:0]   stat_data = '0;
   logic [15:0]   capture_data;
   logic [1:0]    capture_ch;
   logic          capture_valid;
   logic          timeout_err;
   logic          busy;
   logic [3:0]    pending;

   logic [3:0]    ack_d1 = '0;
   logic [3:0]    ack_d2 = '0;
   logic [3:0]    stuck  = '0;
   logic          stray  = 1'b0;

   int            n_chk  = 0;
   int            n_pass = 0;

   logic [1:0]    cap_ch[$];
   logic [15:0]   cap_dat[$];
   int            terr_cnt = 0;
   logic [1:0]    terr_ch;
   logic [15:0]   terr_dat;
   logic [3:0]    terr_we;
   logic          terr_busy;

   cfg_dprio_status_capture_ctrl #(
      .NUM_CH(NCH), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .capture_req(capture_req),
      .write_en(write_en),
      .write_en_ack(write_en_ack),
      .stat_data(stat_data),
      .capture_data(capture_data),
      .capture_ch(capture_ch),
      .capture_valid(capture_valid),
      .timeout_err(timeout_err),
      .busy(busy),
      .pending(pending)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ack_d1 <= write_en;
      ack_d2 <= ack_d1;
   end
   assign write_en_ack = (ack_d2 & ~stuck) | {3'b000, stray};

   always @(negedge clk) begin
      if (capture_valid) begin
         cap_ch.push_back(capture_ch);
         cap_dat.push_back(capture_data);
      end
      if (timeout_err) begin
         terr_cnt++;
         terr_ch   = capture_ch;
         terr_dat  = capture_data;
         terr_we   = write_en;
         terr_busy = busy;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic pulse(input logic [3:0] v);
      @(negedge clk) capture_req = v;
      @(negedge clk) capture_req = '0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((busy || pending != 0) && n < budget);
      chk(tag, 32'(n < budget), 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_we(input string tag, input logic [3:0] v,
                          input int budget);
      int n = 0;
      while (write_en !== v && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(n < budget), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic clear_log();
      cap_ch.delete();
      cap_dat.delete();
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_we", 32'(write_en), 32'd0);
      chk("rst_data", 32'(capture_data), 32'd0);
      chk("rst_ch", 32'(capture_ch), 32'd0);
      chk("rst_valid", 32'(capture_valid), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_pend", 32'(pending), 32'd0);

      // single request on ch2 with exact launch timing
      stat_data[2*DW +: DW] = 16'hA5C3;
      clear_log();
      @(negedge clk) capture_req = 4'b0100;
      @(negedge clk) capture_req = '0;
      chk("one_pend", 32'(pending), 32'h4);
      chk("one_busy0", 32'(busy), 32'd0);
      @(negedge clk);
      chk("one_busy1", 32'(busy), 32'd1);
      chk("one_we0", 32'(write_en), 32'd0);
      @(negedge clk);
      chk("one_we", 32'(write_en), 32'h4);
      wait_idle("one_idle", 50);
      chk("one_cnt", 32'(cap_ch.size()), 32'd1);
      if (cap_ch.size() == 1) begin
         chk("one_ch", 32'(cap_ch[0]), 32'd2);
         chk("one_dat", 32'(cap_dat[0]), 32'hA5C3);
      end
      chk("one_pend0", 32'(pending), 32'd0);

      // round robin from reset pointer
      do_reset();
      stat_data = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
      clear_log();
      pulse(4'b1111);
      wait_idle("rr_idle", 120);
      chk("rr_cnt", 32'(cap_ch.size()), 32'd4);
      for (int i = 0; i < 4 && i < cap_ch.size(); i++) begin
         chk($sformatf("rr_ch%0d", i), 32'(cap_ch[i]), 32'(i));
         chk($sformatf("rr_dat%0d", i), 32'(cap_dat[i]),
             32'(stat_data[i*DW +: DW]));
      end
      clear_log();
      pulse(4'b0011);
      wait_idle("rr2_idle", 80);
      chk("rr2_cnt", 32'(cap_ch.size()), 32'd2);
      if (cap_ch.size() == 2) begin
         chk("rr2_ch0", 32'(cap_ch[0]), 32'd0);
         chk("rr2_ch1", 32'(cap_ch[1]), 32'd1);
      end

      // re-request ch1 while it sits in DROP
      stat_data[1*DW +: DW] = 16'h1234;
      clear_log();
      pulse(4'b0010);
      wait_we("rq_up", 4'b0010, 30);
      wait_we("rq_dn", 4'b0000, 30);
      @(negedge clk) capture_req = 4'b0010;
      @(negedge clk) capture_req = '0;
      begin
         int n = 0;
         while (cap_ch.size() < 1 && n < 30) begin
            @(negedge clk);
            n++;
         end
      end
      stat_data[1*DW +: DW] = 16'hBEEF;
      wait_idle("rq_idle", 80);
      chk("rq_cnt", 32'(cap_ch.size()), 32'd2);
      if (cap_ch.size() == 2) begin
         chk("rq_ch0", 32'(cap_ch[0]), 32'd1);
         chk("rq_ch1", 32'(cap_ch[1]), 32'd1);
         chk("rq_dat0", 32'(cap_dat[0]), 32'h1234);
         chk("rq_dat1", 32'(cap_dat[1]), 32'hBEEF);
      end

      // stray ack on ch0 while ch2 is granted
      stat_data[2*DW +: DW] = 16'h5A5A;
      clear_log();
      pulse(4'b0100);
      repeat (12) @(negedge clk) stray = ~stray;
      stray = 1'b0;
      wait_idle("st_idle", 80);
      chk("st_cnt", 32'(cap_ch.size()), 32'd1);
      if (cap_ch.size() == 1) begin
         chk("st_ch", 32'(cap_ch[0]), 32'd2);
         chk("st_dat", 32'(cap_dat[0]), 32'h5A5A);
      end

      // reset in DROP, then a clean service
      stat_data[3*DW +: DW] = 16'h3C3C;
      pulse(4'b1000);
      wait_we("mr_up", 4'b1000, 30);
      wait_we("mr_dn", 4'b0000, 30);
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      chk("mr_we", 32'(write_en), 32'd0);
      chk("mr_data", 32'(capture_data), 32'd0);
      chk("mr_ch", 32'(capture_ch), 32'd0);
      chk("mr_busy", 32'(busy), 32'd0);
      chk("mr_pend", 32'(pending), 32'd0);
      chk("mr_valid", 32'(capture_valid), 32'd0);
      stat_data[0 +: DW] = 16'hC0DE;
      clear_log();
      pulse(4'b0001);
      wait_idle("mr_idle", 50);
      chk("mr_cnt", 32'(cap_ch.size()), 32'd1);
      if (cap_ch.size() == 1)
         chk("mr_dat", 32'(cap_dat[0]), 32'hC0DE);

      // ch3 never acknowledges
      stuck = 4'b1000;
      pulse(4'b1000);
`ifdef CFG_DPRIO_STATUS_TIMEOUT_EN
      begin
         int n = 0;
         while (terr_cnt == 0 && n < 60) begin
            @(negedge clk);
            n++;
         end
      end
      chk("to_cnt", 32'(terr_cnt), 32'd1);
      chk("to_ch", 32'(terr_ch), 32'd3);
      chk("to_dat", 32'(terr_dat), 32'hC0DE);
      chk("to_we", 32'(terr_we), 32'd0);
      chk("to_busy", 32'(terr_busy), 32'd0);
      @(negedge clk);
      chk("to_pend", 32'(pending), 32'd0);
`else
      repeat (100) @(negedge clk);
      chk("nt_busy", 32'(busy), 32'd1);
      chk("nt_terr", 32'(terr_cnt), 32'd0);
      chk("nt_we", 32'(write_en), 32'h8);
`endif
      stuck = '0;
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
